// File: rtl/wino_tile_gen.sv
// wino_tile_gen: raster pixel stream -> overlapping 4x4 tiles at stride 2,
// feeding the X00..X33 inputs of a Winograd F(2x2,3x3) input transform.
// A four-row circular line buffer holds recent rows. A single-entry output
// register applies backpressure only to pixels that complete a tile.
module wino_tile_gen #(
  parameter int DW    = 16,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DW-1:0]         pix_data,
  output logic                         tile_valid,
  input  logic                         tile_ready,
  output logic [16*DW-1:0]             tile_data,
  output logic [$clog2(IMG_H/2)-1:0]   tile_row,
  output logic [$clog2(IMG_W/2)-1:0]   tile_col,
  output logic                         tile_last
);

  localparam int CCW = $clog2(IMG_W);
  localparam int RCW = $clog2(IMG_H);
  localparam int TRW = $clog2(IMG_H/2);
  localparam int TCW = $clog2(IMG_W/2);

  logic [CCW-1:0]        col_cnt;
  logic [RCW-1:0]        row_cnt;
  logic signed [DW-1:0]  lbuf [4][IMG_W];

  logic                  completes_p0;
  logic                  accept_p0;
  logic                  load_p0;
  logic                  col_end_p0;
  logic                  frame_end_p0;
  logic [16*DW-1:0]      tile_p0;

  // Handshake decode: only a tile-completing pixel can be stalled, and only
  // while the output register still holds an unconsumed tile.
  always_comb begin
    completes_p0 = row_cnt[0] && (row_cnt >= RCW'(3)) &&
                   col_cnt[0] && (col_cnt >= CCW'(3));
    col_end_p0   = (col_cnt == CCW'(IMG_W-1));
    frame_end_p0 = col_end_p0 && (row_cnt == RCW'(IMG_H-1));
    pix_ready    = !(completes_p0 && tile_valid && !tile_ready);
    accept_p0    = pix_valid && pix_ready;
    load_p0      = accept_p0 && completes_p0;
  end

  // Raster position counters; wrap at end of row and end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept_p0) begin
      if (col_end_p0) begin
        col_cnt <= '0;
        row_cnt <= frame_end_p0 ? '0 : row_cnt + RCW'(1);
      end else begin
        col_cnt <= col_cnt + CCW'(1);
      end
    end
  end

  // Line buffer write: row r lands in slot r mod 4, overwriting row r-4.
  always_ff @(posedge clk) begin
    if (accept_p0)
      lbuf[row_cnt[1:0]][col_cnt] <= pix_data;
  end

  // Tile gather: row r-3+i lives in slot (r+1+i) mod 4; X33 bypasses the
  // buffer and comes straight from the incoming pixel.
  always_comb begin
    logic [1:0]     slot;
    logic [CCW-1:0] col;
    tile_p0 = '0;
    slot    = '0;
    col     = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        slot = row_cnt[1:0] + 2'(i + 1);
        col  = col_cnt - CCW'(3 - j);
        if (i == 3 && j == 3)
          tile_p0[(4*i+j)*DW +: DW] = pix_data;
        else
          tile_p0[(4*i+j)*DW +: DW] = lbuf[slot][col];
      end
    end
  end

  // ---- stage p0 -> p1: single-entry output register ----
  // Output register: load wins over consume, contents held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_valid <= 1'b0;
      tile_data  <= '0;
      tile_row   <= '0;
      tile_col   <= '0;
      tile_last  <= 1'b0;
    end else if (load_p0) begin
      tile_valid <= 1'b1;
      tile_data  <= tile_p0;
      tile_row   <= TRW'((row_cnt - RCW'(3)) >> 1);
      tile_col   <= TCW'((col_cnt - CCW'(3)) >> 1);
      tile_last  <= frame_end_p0;
    end else if (tile_valid && tile_ready) begin
      tile_valid <= 1'b0;
    end
  end

endmodule

// File: doc/wino_tile_gen.md
Name: wino_tile_gen

Overview:
- Upstream feeder for the Winograd F(2x2,3x3) input-transform stage.
- Accepts a raster-order pixel stream and holds the last four image rows in a circular line buffer.
- Emits overlapping 4x4 tiles at stride 2 in both directions, one flattened tile per handshake, wired directly onto the X00..X33 inputs of the transform.
- Output register is single-entry, with backpressure to the pixel source.

Parameters:
- DW, 16, signed pixel width; equals the transform's DW.
- IMG_W, 16, image width in pixels; even, >= 4.
- IMG_H, 16, image height in rows; even, >= 4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- pix_valid  in  1  pixel stream valid.
- pix_ready  out  1  pixel stream ready.
- pix_data  in  DW  signed pixel, raster order (row-major, left to right).
- tile_valid  out  1  tile output valid.
- tile_ready  in  1  downstream (transform) ready.
- tile_data  out  16*DW  tile; element X_ij at bits [(4*i+j)*DW +: DW], where i = row 0..3 and j = col 0..3.
- tile_row  out  clog2(IMG_H/2)  tile row index tr; top pixel row is 2*tr.
- tile_col  out  clog2(IMG_W/2)  tile column index tc; left pixel column is 2*tc.
- tile_last  out  1  set on the final tile of a frame.

Behaviour:
- Reset (async, rst_n=0):
  - Column counter c and row counter r go to 0.
  - tile_valid, tile_last, tile_row and tile_col go to 0; tile_data goes to 0.
  - Line-buffer contents are not cleared. Their contents are don't-care, because no tile can be formed before 4 new rows arrive.
- Pixel handshake: a pixel is accepted when pix_valid && pix_ready.
  - The pixel is written to line-buffer slot (r mod 4), column c.
  - c increments; when c = IMG_W-1, c wraps to 0 and r increments.
  - When r = IMG_H-1 and c = IMG_W-1, both counters wrap to 0 and a new frame begins with no other state change.
- Tile completion: an accepted pixel at (r,c) completes a tile iff r >= 3, r odd, c >= 3 and c odd.
  - The tile covers rows r-3..r and columns c-3..c.
  - Rows r-3..r-1 and row r columns c-3..c-1 come from the buffer; X33 is the incoming pix_data itself (bypass, no buffer read-after-write hazard).
  - On the next clock edge, the output register loads the tile, with tile_row = (r-3)/2 and tile_col = (c-3)/2.
  - tile_last = 1 iff r = IMG_H-1 and c = IMG_W-1.
  - tile_valid goes to 1.
- Latency: tile_valid rises exactly 1 cycle after the completing pixel's handshake.
- Output register:
  - tile_valid clears on tile_valid && tile_ready unless a new tile loads in the same cycle.
  - Simultaneous accept-and-load: the new tile replaces the old one and tile_valid stays 1.
  - tile_data, tile_row, tile_col and tile_last are held stable while tile_valid && !tile_ready.
- Backpressure: pix_ready = !(completes_tile(r,c) && tile_valid && !tile_ready).
  - Only tile-completing pixels stall; all other pixels flow freely.
  - pix_ready depends combinationally on tile_ready and the counters, not on pix_valid.
- Overwrite safety: writing row r overwrites row r-4. All tiles needing row r-4 complete by the end of row r-1, and stalling guarantees they are emitted, so no tile ever reads an overwritten row.
- Tiles per frame: ((IMG_W-4)/2+1) * ((IMG_H-4)/2+1), emitted in raster order of (tr, tc).
- Reset mid-frame: counters restart at 0 and any pending tile is dropped. The next frame starts at row 0, and no tile is emitted until row 3.
- Arithmetic: none on data. Pixels are passed bit-exact and sign is preserved; growth happens downstream.

Test Plan:
1. IMG_W=IMG_H=8, pixel value = 8r+c, tile_ready=1, continuous pix_valid -> exactly 9 tiles.
   - First tile appears 1 cycle after pixel 27 with tr=0, tc=0, X00=0, X03=3, X30=24, X33=27.
   - Last tile has tr=2, tc=2, X00=36, X33=63, tile_last=1; tile_last is 0 on all others.
2. Same stream with tile_ready=0 from the first tile onward -> pix_ready drops only at pixel (3,5) = 29.
   - The tile holds X00=0 stable.
   - Releasing tile_ready for 1 cycle accepts the tile and pixel 29 in the same cycle.
   - The next tile has X00=2, X33=29, and no pixel is lost or duplicated.
3. Random pix_valid gaps (about 50%) and random tile_ready -> the tile sequence is identical to scenario 1 against a reference model; tile_data never changes while tile_valid && !tile_ready.
4. Two back-to-back frames with pixel value = 64*frame + 8r+c -> 18 tiles.
   - Tile 10 has X00=64, X33=91.
   - tile_last is set only on tiles 9 and 18.
5. rst_n pulsed low asynchronously mid-clock at pixel 40 while a tile is pending -> tile_valid=0 immediately.
   - Restarting with value = 8r+c reproduces scenario 1 exactly.
6. Negative data: all pixels = -32768 (DW=16) -> every tile element reads 0x8000; sign preserved.
